video_fill_engine: RTL

- Bus-master fill engine that sits directly upstream of soc_video on its CPU-side write port (sel/wren/address/data).
- The CPU programs a destination address, a byte length and a fill byte, then starts the engine.
- The engine issues back-to-back byte writes into video char/attribute memory (0xF00000 / 0xE00000 regions), so the CPU no longer clears or fills the screen byte by byte.
- One clock domain (clk_cpu side).

---
 rtl/video_fill_engine_if.sv | 41 ++++
 rtl/video_fill_engine.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/video_fill_engine_if.sv
// Bus bundle for video_fill_engine: CPU-side config port plus the
// byte-write port that feeds soc_video (sel/wren/address/data).
// The engine connects through the slave modport; the CPU/bench side uses master.
interface video_fill_engine_if #(
    parameter int ADDR_W = 24
);
    logic              cfg_sel;
    logic [3:0]        cfg_wren;
    logic [3:0]        cfg_address;
    logic [31:0]       cfg_data_in;
    logic [31:0]       cfg_data_out;

    logic              video_sel;
    logic [3:0]        video_wren;
    logic [ADDR_W-1:0] video_address;
    logic [31:0]       video_data;

    modport master (
        output cfg_sel,
        output cfg_wren,
        output cfg_address,
        output cfg_data_in,
        input  cfg_data_out,
        input  video_sel,
        input  video_wren,
        input  video_address,
        input  video_data
    );

    modport slave (
        input  cfg_sel,
        input  cfg_wren,
        input  cfg_address,
        input  cfg_data_in,
        output cfg_data_out,
        output video_sel,
        output video_wren,
        output video_address,
        output video_data
    );
endinterface

// File: rtl/video_fill_engine.sv
// video_fill_engine: bus-master fill engine in front of soc_video's CPU write
// port. The CPU programs DST/LEN/FILL and pulses START; the engine then issues
// LEN back-to-back byte writes of FILL into video memory.
// Optional build macro: VIDEO_FILL_WORD_EN -- aligned stretches with at least
// four bytes remaining are written as one full-word write (wren 1111).
module video_fill_engine #(
    parameter int ADDR_W     = 24,
    parameter int LEN_W      = 12,
    parameter int GAP_CYCLES = 0
) (
    input  logic                clk,
    input  logic                n_reset,
    video_fill_engine_if.slave  bus,
    output logic                busy,
    output logic                done_irq
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WRITE  = 2'd1,
        ST_GAP    = 2'd2,
        ST_FINISH = 2'd3
    } state_t;

    // Shadow (programmed) registers
    logic [ADDR_W-1:0] dst_r;
    logic [LEN_W-1:0]  len_r;
    logic [7:0]        fill_r;
    logic              done_r;
    logic              busy_r;

    // Working copies for the active run
    state_t            state_r;
    logic [ADDR_W-1:0] work_addr_r;
    logic [LEN_W-1:0]  work_rem_r;
    logic [7:0]        work_fill_r;
    logic [15:0]       gap_cnt_r;

    // Registered outputs
    logic [31:0]       rd_data_r;
    logic              vid_sel_r;
    logic [3:0]        vid_wren_r;
    logic [ADDR_W-1:0] vid_addr_r;
    logic [31:0]       vid_data_r;

    // Decode / datapath helpers
    logic              cfg_wr_s;
    logic              cfg_rd_s;
    logic              wr_dst_s;
    logic              wr_len_s;
    logic              wr_fill_s;
    logic              wr_ctrl_s;
    logic              start_s;
    logic              abort_s;
    logic              done_clr_s;
    logic              st_word_s;
    logic              cur_word_s;
    logic              nxt_word_s;
    logic [ADDR_W-1:0] nxt_addr_s;
    logic [LEN_W-1:0]  nxt_rem_s;

    // Byte-lane merge of a config write into an existing register value
    function automatic logic [31:0] lane_merge(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  en);
        logic [31:0] r;
        r = old_v;
        for (int i = 0; i < 4; i++) begin
            if (en[i]) begin
                r[i*8 +: 8] = new_v[i*8 +: 8];
            end else begin
                r[i*8 +: 8] = old_v[i*8 +: 8];
            end
        end
        return r;
    endfunction

    // Lane strobe for one write: full word, or one-hot from the low address bits
    function automatic logic [3:0] lane_strobe(input logic [1:0] a, input logic word);
        logic [3:0] s;
        if (word) begin
            s = 4'b1111;
        end else begin
            case (a)
                2'b00:   s = 4'b0001;
                2'b01:   s = 4'b0010;
                2'b10:   s = 4'b0100;
                2'b11:   s = 4'b1000;
                default: s = 4'b0001;
            endcase
        end
        return s;
    endfunction

    // Config access decode and write-size selection for the current/next write
    always_comb begin
        cfg_wr_s   = bus.cfg_sel && (bus.cfg_wren != 4'b0000);
        cfg_rd_s   = bus.cfg_sel && (bus.cfg_wren == 4'b0000);
        wr_dst_s   = 1'b0;
        wr_len_s   = 1'b0;
        wr_fill_s  = 1'b0;
        wr_ctrl_s  = 1'b0;
        case (bus.cfg_address)
            4'h0:    wr_dst_s  = cfg_wr_s;
            4'h4:    wr_len_s  = cfg_wr_s;
            4'h8:    wr_fill_s = cfg_wr_s;
            4'hC:    wr_ctrl_s = cfg_wr_s;
            default: wr_dst_s  = 1'b0;
        endcase
        start_s    = wr_ctrl_s && bus.cfg_wren[0] && bus.cfg_data_in[0];
        done_clr_s = wr_ctrl_s && bus.cfg_wren[0] && bus.cfg_data_in[2];
        abort_s    = wr_ctrl_s && bus.cfg_wren[0] && bus.cfg_data_in[3];

`ifdef VIDEO_FILL_WORD_EN
        st_word_s  = (dst_r[1:0] == 2'b00) && (len_r >= LEN_W'(3'd4));
        cur_word_s = (work_addr_r[1:0] == 2'b00) && (work_rem_r >= LEN_W'(3'd4));
`else
        st_word_s  = 1'b0;
        cur_word_s = 1'b0;
`endif
        if (cur_word_s) begin
            nxt_addr_s = work_addr_r + ADDR_W'(3'd4);
            nxt_rem_s  = work_rem_r - LEN_W'(3'd4);
        end else begin
            nxt_addr_s = work_addr_r + ADDR_W'(1'b1);
            nxt_rem_s  = work_rem_r - LEN_W'(1'b1);
        end
`ifdef VIDEO_FILL_WORD_EN
        nxt_word_s = (nxt_addr_s[1:0] == 2'b00) && (nxt_rem_s >= LEN_W'(3'd4));
`else
        nxt_word_s = 1'b0;
`endif
    end

    // Shadow registers: lane-masked CPU writes, independent of any active run
    always_ff @(posedge clk) begin
        if (!n_reset) begin
            dst_r  <= '0;
            len_r  <= '0;
            fill_r <= 8'h00;
        end else begin
            if (wr_dst_s) begin
                dst_r <= ADDR_W'(lane_merge(32'(dst_r), bus.cfg_data_in, bus.cfg_wren));
            end
            if (wr_len_s) begin
                len_r <= LEN_W'(lane_merge(32'(len_r), bus.cfg_data_in, bus.cfg_wren));
            end
            if (wr_fill_s && bus.cfg_wren[0]) begin
                fill_r <= bus.cfg_data_in[7:0];
            end
        end
    end

    // Fill FSM: run control, working copies, DONE/BUSY and the video write port
    always_ff @(posedge clk) begin
        if (!n_reset) begin
            state_r     <= ST_IDLE;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            work_addr_r <= '0;
            work_rem_r  <= '0;
            work_fill_r <= 8'h00;
            gap_cnt_r   <= 16'd0;
            vid_sel_r   <= 1'b0;
            vid_wren_r  <= 4'b0000;
            vid_addr_r  <= '0;
            vid_data_r  <= 32'h0000_0000;
        end else begin
            // W1C first so that a same-cycle FINISH set overrides it
            if (done_clr_s) begin
                done_r <= 1'b0;
            end
            case (state_r)
                ST_IDLE: begin
                    vid_sel_r  <= 1'b0;
                    vid_wren_r <= 4'b0000;
                    if (start_s) begin
                        if (len_r != '0) begin
                            state_r     <= ST_WRITE;
                            busy_r      <= 1'b1;
                            work_addr_r <= dst_r;
                            work_rem_r  <= len_r;
                            work_fill_r <= fill_r;
                            vid_sel_r   <= 1'b1;
                            vid_addr_r  <= dst_r;
                            vid_wren_r  <= lane_strobe(dst_r[1:0], st_word_s);
                            vid_data_r  <= {4{fill_r}};
                        end else begin
                            // Empty run: no writes, DONE on the following edge
                            state_r <= ST_FINISH;
                        end
                    end
                end
                ST_WRITE: begin
                    if (abort_s) begin
                        state_r    <= ST_IDLE;
                        busy_r     <= 1'b0;
                        vid_sel_r  <= 1'b0;
                        vid_wren_r <= 4'b0000;
                    end else begin
                        work_addr_r <= nxt_addr_s;
                        work_rem_r  <= nxt_rem_s;
                        if (nxt_rem_s == '0) begin
                            state_r    <= ST_FINISH;
                            vid_sel_r  <= 1'b0;
                            vid_wren_r <= 4'b0000;
                        end else if (GAP_CYCLES > 0) begin
                            state_r    <= ST_GAP;
                            gap_cnt_r  <= 16'(GAP_CYCLES - 1);
                            vid_sel_r  <= 1'b0;
                            vid_wren_r <= 4'b0000;
                        end else begin
                            vid_sel_r  <= 1'b1;
                            vid_addr_r <= nxt_addr_s;
                            vid_wren_r <= lane_strobe(nxt_addr_s[1:0], nxt_word_s);
                            vid_data_r <= {4{work_fill_r}};
                        end
                    end
                end
                ST_GAP: begin
                    if (abort_s) begin
                        state_r    <= ST_IDLE;
                        busy_r     <= 1'b0;
                        vid_sel_r  <= 1'b0;
                        vid_wren_r <= 4'b0000;
                    end else if (gap_cnt_r == 16'd0) begin
                        state_r    <= ST_WRITE;
                        vid_sel_r  <= 1'b1;
                        vid_addr_r <= work_addr_r;
                        vid_wren_r <= lane_strobe(work_addr_r[1:0], cur_word_s);
                        vid_data_r <= {4{work_fill_r}};
                    end else begin
                        gap_cnt_r <= gap_cnt_r - 16'd1;
                    end
                end
                ST_FINISH: begin
                    vid_sel_r  <= 1'b0;
                    vid_wren_r <= 4'b0000;
                    state_r    <= ST_IDLE;
                    busy_r     <= 1'b0;
                    if (!(abort_s && busy_r)) begin
                        done_r <= 1'b1;
                    end
                end
                default: begin
                    state_r    <= ST_IDLE;
                    busy_r     <= 1'b0;
                    vid_sel_r  <= 1'b0;
                    vid_wren_r <= 4'b0000;
                end
            endcase
        end
    end

    // Registered config read port: loaded on read strobes, held otherwise
    always_ff @(posedge clk) begin
        if (!n_reset) begin
            rd_data_r <= 32'h0000_0000;
        end else if (cfg_rd_s) begin
            case (bus.cfg_address)
                4'h0:    rd_data_r <= 32'(dst_r);
                4'h4:    rd_data_r <= 32'(len_r);
                4'h8:    rd_data_r <= {24'h00_0000, fill_r};
                4'hC:    rd_data_r <= {28'h000_0000, 1'b0, done_r, busy_r, 1'b0};
                default: rd_data_r <= 32'h0000_0000;
            endcase
        end
    end

    assign bus.cfg_data_out  = rd_data_r;
    assign bus.video_sel     = vid_sel_r;
    assign bus.video_wren    = vid_wren_r;
    assign bus.video_address = vid_addr_r;
    assign bus.video_data    = vid_data_r;
    assign busy              = busy_r;
    assign done_irq          = done_r;

endmodule
